snn_host_ctrl: RTL and testbench

Host-side image sender for the SNN digit classifier: the other end of the UART image protocol. On `go`, reads a 784-pixel binary image from a 1-bit-wide synchronous ROM, packs it into 98 bytes and sends them through a byte-level UART transmitter. It then waits for the single classification byte from the UART receiver and reports the digit with range and timeout errors. It sits on the board/host FPGA between the image ROM, `uart_tx` and `uart_rx`.

---
 rtl/snn_host_pkg.sv | 31 +++
 rtl/snn_host_if.sv | 23 ++
 rtl/snn_host_ctrl_resp_timer.sv | 32 +++
 rtl/snn_host_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_snn_host_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_host_pkg.sv
// Shared types and sizes for the host-side image sender.
package snn_host_pkg;

  localparam int unsigned IMG_BITS      = 784;
  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned NUM_BYTES     = IMG_BITS / BITS_PER_BYTE;
  localparam int unsigned MAX_DIGIT     = 9;
  localparam int unsigned ADDR_W        = 10;
  localparam int unsigned BYTE_IDX_W    = 7;
  localparam int unsigned BIT_IDX_W     = 3;
  localparam int unsigned CNT_W         = 4;
  localparam int unsigned FETCH_CYC     = BITS_PER_BYTE + 1;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned DIGIT_W       = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    TX_WAIT,
    RESP_WAIT,
    FINISH
  } state_t;

  // ROM bit address of bit k within image byte n
  function automatic logic [ADDR_W-1:0] bit_addr(input logic [BYTE_IDX_W-1:0] n,
                                                 input logic [BIT_IDX_W-1:0]  k);
    return {n, k};
  endfunction

endpackage

// File: rtl/snn_host_if.sv
// Image ROM and UART byte-level signals seen by the host controller.
interface snn_host_if;
  import snn_host_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_q;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_rdy;
  logic              rx_rdy;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output rom_addr, tx_start, tx_data,
    input  rom_q, tx_rdy, rx_rdy, rx_data
  );

  modport slave (
    input  rom_addr, tx_start, tx_data,
    output rom_q, tx_rdy, rx_rdy, rx_data
  );

endinterface

// File: rtl/snn_host_ctrl_resp_timer.sv
// Response timeout counter: expired is high on the cycle the count equals TIMEOUT-1.
module resp_timer #(
  parameter int unsigned TIMEOUT = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // expired is registered one step early so it lines up with count == TIMEOUT-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clr) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (en) begin
      count   <= count + CW'(1);
      expired <= (count == CW'(TIMEOUT - 2));
    end else begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/snn_host_ctrl.sv
// Sends a 784-bit ROM image as 98 UART bytes, then waits for the classification byte.
module snn_host_ctrl
  import snn_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = 5_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  snn_host_if.master         bus,
  output logic               busy,
  output logic               done,
  output logic [DIGIT_W-1:0] digit,
  output logic               err_timeout,
  output logic               err_range
);

  state_t                state_q, state_n;
  logic [BYTE_IDX_W-1:0] n_q, n_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [ADDR_W-1:0]     rom_addr_q, rom_addr_n;
  logic                  tx_start_q, tx_start_n;
  logic [DATA_W-1:0]     tx_data_q, tx_data_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic [DIGIT_W-1:0]    digit_q, digit_n;
  logic                  err_timeout_q, err_timeout_n;
  logic                  err_range_q, err_range_n;
  logic                  tmr_clr, tmr_en, tmr_expired;
  logic                  last_byte_c;

  assign last_byte_c = (n_q == BYTE_IDX_W'(NUM_BYTES - 1));

  resp_timer #(.TIMEOUT(TIMEOUT)) u_resp_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      n_q           <= '0;
      cnt_q         <= '0;
      rom_addr_q    <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      digit_q       <= '0;
      err_timeout_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      state_q       <= state_n;
      n_q           <= n_n;
      cnt_q         <= cnt_n;
      rom_addr_q    <= rom_addr_n;
      tx_start_q    <= tx_start_n;
      tx_data_q     <= tx_data_n;
      busy_q        <= busy_n;
      done_q        <= done_n;
      digit_q       <= digit_n;
      err_timeout_q <= err_timeout_n;
      err_range_q   <= err_range_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state_q;
    n_n           = n_q;
    cnt_n         = cnt_q;
    rom_addr_n    = rom_addr_q;
    tx_start_n    = 1'b0;
    tx_data_n     = tx_data_q;
    busy_n        = busy_q;
    done_n        = 1'b0;
    digit_n       = digit_q;
    err_timeout_n = err_timeout_q;
    err_range_n   = err_range_q;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          n_n           = '0;
          cnt_n         = '0;
          rom_addr_n    = bit_addr('0, '0);
          err_timeout_n = 1'b0;
          err_range_n   = 1'b0;
          busy_n        = 1'b1;
          state_n       = FETCH;
        end
      end

      // cnt 0..7 presents address k=cnt; rom_q for k=cnt-1 arrives one cycle later
      FETCH: begin
        if (cnt_q != '0) begin
          tx_data_n[BIT_IDX_W'(cnt_q - CNT_W'(1))] = bus.rom_q;
        end
        if (cnt_q < CNT_W'(BITS_PER_BYTE - 1)) begin
          rom_addr_n = bit_addr(n_q, BIT_IDX_W'(cnt_q + CNT_W'(1)));
        end
        if (cnt_q == CNT_W'(FETCH_CYC - 1)) begin
          cnt_n   = '0;
          state_n = SEND;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      SEND: begin
        if (bus.tx_rdy) begin
          tx_start_n = 1'b1;
          cnt_n      = '0;
          state_n    = TX_WAIT;
        end
      end

      // First cycle skipped: tx_rdy only drops after the transmitter sees tx_start
      TX_WAIT: begin
        if (cnt_q == '0) begin
          cnt_n = CNT_W'(1);
        end else if (bus.tx_rdy) begin
          cnt_n = '0;
          if (last_byte_c) begin
            tmr_clr = 1'b1;
            state_n = RESP_WAIT;
          end else begin
            n_n        = n_q + BYTE_IDX_W'(1);
            rom_addr_n = bit_addr(n_q + BYTE_IDX_W'(1), BIT_IDX_W'(0));
            state_n    = FETCH;
          end
        end
      end

      // A received byte takes priority over a coincident timeout
      RESP_WAIT: begin
        tmr_en = 1'b1;
        if (bus.rx_rdy) begin
          if (bus.rx_data <= DATA_W'(MAX_DIGIT)) begin
            digit_n = bus.rx_data[DIGIT_W-1:0];
          end else begin
            err_range_n = 1'b1;
          end
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = FINISH;
        end else if (tmr_expired) begin
          err_timeout_n = 1'b1;
          done_n        = 1'b1;
          busy_n        = 1'b0;
          state_n       = FINISH;
        end
      end

      FINISH: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign digit        = digit_q;
  assign err_timeout  = err_timeout_q;
  assign err_range    = err_range_q;

endmodule

// File: tb/tb_snn_host_ctrl.sv
// Scoreboard bench for snn_host_ctrl: ROM/UART models, random images and responses.
module tb_snn_host_ctrl;

  localparam int TIMEOUT   = 1000;
  localparam int NBYTES    = 98;
  localparam int UART_CYC  = 12;

  logic       clk;
  logic       rst_n;
  logic       go;
  logic       busy, done, err_timeout, err_range;
  logic [3:0] digit;

  snn_host_if bus ();

  snn_host_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .digit       (digit),
    .err_timeout (err_timeout),
    .err_range   (err_range)
  );

  // Environment: ROM, UART transmitter, receiver pulses
  bit         rom_mem [0:1023];
  logic       uart_idle = 1'b1;
  int         uart_cnt  = 0;
  logic       hold_low  = 1'b0;
  logic       rx_rdy_drv = 1'b0;
  logic [7:0] rx_data_drv = 8'h00;
  logic       rom_q_r = 1'b0;
  int         cyc = 0;

  assign bus.tx_rdy  = uart_idle & ~hold_low;
  assign bus.rx_rdy  = rx_rdy_drv;
  assign bus.rx_data = rx_data_drv;
  assign bus.rom_q   = rom_q_r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q_r <= rom_mem[bus.rom_addr];

  always @(posedge clk) begin
    if (bus.tx_start) begin
      uart_idle <= 1'b0;
      uart_cnt  <= UART_CYC;
    end else if (!uart_idle) begin
      if (uart_cnt == 1) uart_idle <= 1'b1;
      uart_cnt <= uart_cnt - 1;
    end
  end

  // Scoreboard
  typedef struct {
    logic [3:0] digit;
    logic       er;
    logic       et;
    int         cyc;
  } exp_t;

  logic [7:0] exp_bytes [$];
  exp_t       exp_done  [$];
  int         n_total = 0;
  int         n_pass  = 0;
  int         sent = 0;
  int         dones = 0;
  int         frame_bytes = 0;
  int         addr_bad = 0;
  logic [9:0] last_addr = '0;
  logic       prev_busy = 1'b0;
  logic [3:0] model_digit = 4'd0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endfunction

  // Monitor: pops expectations whenever the DUT emits a byte or a done pulse
  initial begin
    logic [7:0] eb;
    exp_t       ed;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          chk("first_addr", 32'(bus.rom_addr), 32'd0);
          last_addr   = bus.rom_addr;
          addr_bad    = 0;
          frame_bytes = 0;
        end else if (busy && bus.rom_addr != last_addr) begin
          if (bus.rom_addr != last_addr + 10'd1 || bus.rom_addr > 10'd783) addr_bad++;
          last_addr = bus.rom_addr;
        end
        prev_busy = busy;

        if (bus.tx_start) begin
          sent++;
          frame_bytes++;
          if (exp_bytes.size() == 0) begin
            n_total++;
            $display("FAIL tx_unexpected: got byte %02h, expected no byte (cycle %0d)", bus.tx_data, cyc);
          end else begin
            eb = exp_bytes.pop_front();
            chk("tx_byte", 32'(bus.tx_data), 32'(eb));
          end
          chk("flags_on_tx", 32'({busy, err_range, err_timeout}), 32'(3'b100));
        end

        if (done) begin
          dones++;
          if (exp_done.size() == 0) begin
            n_total++;
            $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
          end else begin
            ed = exp_done.pop_front();
            chk("digit", 32'(digit), 32'(ed.digit));
            chk("err_range", 32'(err_range), 32'(ed.er));
            chk("err_timeout", 32'(err_timeout), 32'(ed.et));
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("done_cycle", 32'(cyc), 32'(ed.cyc));
            chk("frame_bytes", 32'(frame_bytes), 32'(NBYTES));
            chk("addr_order", 32'(addr_bad), 32'd0);
            chk("last_addr", 32'(last_addr), 32'd783);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sent(input int target, input string what);
    int budget = 20000;
    while (sent < target && budget > 0) begin tick(); budget--; end
    if (sent < target) begin
      n_total++;
      $display("FAIL wait_%s: sent %0d bytes, required %0d", what, sent, target);
    end
  endtask

  task automatic wait_tx_rdy(output int at);
    int budget = 2000;
    while (!bus.tx_rdy && budget > 0) begin tick(); budget--; end
    if (!bus.tx_rdy) begin
      n_total++;
      $display("FAIL wait_tx_rdy: tx_rdy %0b, required 1", bus.tx_rdy);
    end
    at = cyc;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    chk({tag, "_tx_data"},  32'(bus.tx_data),  32'd0);
    chk({tag, "_busy"},     32'(busy),         32'd0);
    chk({tag, "_done"},     32'(done),         32'd0);
    chk({tag, "_digit"},    32'(digit),        32'd0);
    chk({tag, "_err_t"},    32'(err_timeout),  32'd0);
    chk({tag, "_err_r"},    32'(err_range),    32'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) rom_mem[i] = (i < 784) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // mode: 0 respond, 1 silent, 2 stress, 3 reset at byte 40, 4 respond then go on done cycle
  task automatic run_frame(input int mode, input logic [7:0] resp, input int delay);
    int         base, dbase, r_cyc, budget;
    logic       er;
    logic [7:0] b;
    base  = sent;
    dbase = dones;
    for (int i = 0; i < NBYTES; i++) begin
      for (int j = 0; j < 8; j++) b[j] = rom_mem[8*i + j];
      exp_bytes.push_back(b);
    end
    go = 1'b1; tick(); go = 1'b0;

    if (mode == 3) begin
      wait_sent(base + 40, "b40");
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check_reset("midreset");
      exp_bytes.delete();
      model_digit = 4'd0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (40) tick();
      chk("idle_after_reset", 32'(busy), 32'd0);
      return;
    end

    if (mode == 2) begin
      wait_sent(base + 10, "b10");
      wait_tx_rdy(r_cyc);
      repeat (3) tick();
      hold_low = 1'b1;
      repeat (10) tick();
      go = 1'b1; tick(); go = 1'b0;
      repeat (10) tick();
      rx_data_drv = 8'($urandom_range(0, 9));
      rx_rdy_drv = 1'b1; tick(); rx_rdy_drv = 1'b0;
      repeat (28) tick();
      hold_low = 1'b0;
      wait_sent(base + 60, "b60");
      go = 1'b1; rx_rdy_drv = 1'b1; tick(); go = 1'b0; rx_rdy_drv = 1'b0;
    end

    wait_sent(base + NBYTES, "frame");
    wait_tx_rdy(r_cyc);

    if (mode == 1) begin
      exp_done.push_back('{model_digit, 1'b0, 1'b1, r_cyc + TIMEOUT + 1});
    end else begin
      while (cyc < r_cyc + delay) tick();
      rx_data_drv = resp;
      er = (resp > 8'd9);
      if (!er) model_digit = resp[3:0];
      exp_done.push_back('{model_digit, er, 1'b0, cyc + 1});
      rx_rdy_drv = 1'b1; tick(); rx_rdy_drv = 1'b0;
      if (mode == 4) begin go = 1'b1; tick(); go = 1'b0; end
    end

    budget = TIMEOUT + 200;
    while (dones == dbase && budget > 0) begin tick(); budget--; end
    if (dones == dbase) begin
      n_total++;
      $display("FAIL wait_done: got no done, expected one (mode %0d)", mode);
    end
    if (mode == 4) begin
      repeat (30) tick();
      chk("go_on_done_ignored", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    go    = 1'b0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 1'b0;
    rom_mem[0]   = 1'b1;
    rom_mem[783] = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    run_frame(0, 8'h07, 100);
    fill_random();
    run_frame(0, 8'h0C, 37);
    fill_random();
    run_frame(0, 8'($urandom_range(0, 9)), int'($urandom_range(1, 200)));
    run_frame(1, 8'h00, 0);
    fill_random();
    run_frame(2, 8'($urandom_range(0, 15)), int'($urandom_range(1, 300)));
    fill_random();
    run_frame(4, 8'($urandom_range(0, 9)), TIMEOUT);
    run_frame(3, 8'h00, 0);
    fill_random();
    run_frame(0, 8'($urandom_range(0, 9)), int'($urandom_range(1, 200)));

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
